// File: rtl/acc_pkg.sv
// Shared definitions for the accelerator memory arbiter.
//   ACC_DATA_WIDTH / ACC_ADDR_WIDTH : default memory word and address widths
//   acc_state_e                     : arbiter FSM state encoding
package acc_pkg;

    localparam int unsigned ACC_DATA_WIDTH = 16;
    localparam int unsigned ACC_ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2
    } acc_state_e;

endpackage

// File: rtl/acc_arb_pick.sv
// Winner selection for the CPU/IO memory arbiter.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_cpu_req      : CPU request
//   i_io_req       : IO request
//   i_arb          : an arbitration decision is being taken this cycle
//   o_pick_io      : 1 = IO wins, 0 = CPU wins (only meaningful with a request)
// Build option: ACC_ARB_STARVE_GUARD_EN enables the IO starvation counter;
// without it the CPU has strict priority.
module acc_arb_pick #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_cpu_req,
    input  logic i_io_req,
    input  logic i_arb,
    output logic o_pick_io
);

`ifdef ACC_ARB_STARVE_GUARD_EN
    // Extra headroom keeps the width non-zero even for a limit of 0.
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 2);

    logic [CNT_W-1:0] r_cnt;
    logic             w_starved;

    assign w_starved = (r_cnt == CNT_W'(STARVE_LIMIT));
    assign o_pick_io = i_io_req & (~i_cpu_req | w_starved);

    // Counts CPU wins while IO is waiting; cannot exceed the limit because
    // reaching it hands the next decision to IO, which clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_io_req) begin
            r_cnt <= '0;
        end else if (i_arb) begin
            r_cnt <= o_pick_io ? '0 : r_cnt + CNT_W'(1);
        end
    end
`else
    logic w_unused;

    assign o_pick_io = i_io_req & ~i_cpu_req;
    assign w_unused  = i_clk ^ i_rst_n ^ i_arb ^ (^STARVE_LIMIT);
`endif

endmodule

// File: rtl/acc_mem_arbiter.sv
// Two-requester (CPU, IO) arbiter in front of a synchronous-read memory.
//   CLK, Reset                  : clock (rising edge), async active-low reset
//   cpu_* / io_*                : req, we, addr, wdata in; gnt, rvalid, rdata out
//   mem_addr, mem_data, mem_we  : registered memory drive, valid in ACCESS
//   mem_q                       : memory read data, one cycle after the address
//   busy                        : FSM is not IDLE
// Build option: ACC_ARB_STARVE_GUARD_EN (see acc_arb_pick).
module acc_mem_arbiter
    import acc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = ACC_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = ACC_ADDR_WIDTH,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [15:0]           cpu_addr,
    input  logic [15:0]           cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [15:0]           cpu_rdata,
    input  logic                  io_req,
    input  logic                  io_we,
    input  logic [15:0]           io_addr,
    input  logic [15:0]           io_wdata,
    output logic                  io_gnt,
    output logic                  io_rvalid,
    output logic [15:0]           io_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  busy
);

    acc_state_e            r_state;
    acc_state_e            w_state_nxt;
    logic                  r_win_io;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_data;
    logic                  r_mem_we;
    logic [15:0]           r_cpu_rdata;
    logic [15:0]           r_io_rdata;
    logic                  w_any_req;
    logic                  w_load;
    logic                  w_pick_io;
    logic [15:0]           w_q;
    logic                  w_unused_addr;

    assign w_any_req     = cpu_req | io_req;
    assign w_q           = 16'(mem_q);
    // Upper address bits are deliberately dropped.
    assign w_unused_addr = ^{cpu_addr[15:ADDR_WIDTH], io_addr[15:ADDR_WIDTH]};

    acc_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .i_clk     (CLK),
        .i_rst_n   (Reset),
        .i_cpu_req (cpu_req),
        .i_io_req  (io_req),
        .i_arb     (w_load),
        .o_pick_io (w_pick_io)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_state_nxt = ACCESS;
            ACCESS:  w_state_nxt = r_mem_we ? IDLE : RDWAIT;
            RDWAIT:  w_state_nxt = w_any_req ? ACCESS : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // An arbitration happens on every entry into ACCESS.
    assign w_load = (w_state_nxt == ACCESS) && (r_state != ACCESS);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state     <= IDLE;
            r_win_io    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_mem_we    <= 1'b0;
            r_cpu_rdata <= '0;
            r_io_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_win_io   <= w_pick_io;
                r_mem_addr <= w_pick_io ? ADDR_WIDTH'(io_addr) : ADDR_WIDTH'(cpu_addr);
                r_mem_data <= w_pick_io ? DATA_WIDTH'(io_wdata) : DATA_WIDTH'(cpu_wdata);
                r_mem_we   <= w_pick_io ? io_we : cpu_we;
            end else begin
                r_mem_we   <= 1'b0;
            end
            if (cpu_rvalid) r_cpu_rdata <= w_q;
            if (io_rvalid)  r_io_rdata  <= w_q;
        end
    end

    assign busy       = (r_state != IDLE);
    assign cpu_gnt    = (r_state == ACCESS) && !r_win_io;
    assign io_gnt     = (r_state == ACCESS) && r_win_io;
    assign cpu_rvalid = (r_state == RDWAIT) && !r_win_io;
    assign io_rvalid  = (r_state == RDWAIT) && r_win_io;
    // Read data is live from memory during the rvalid pulse, then held.
    assign cpu_rdata  = cpu_rvalid ? w_q : r_cpu_rdata;
    assign io_rdata   = io_rvalid ? w_q : r_io_rdata;
    assign mem_addr   = r_mem_addr;
    assign mem_data   = r_mem_data;
    assign mem_we     = r_mem_we;

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// Directed self-checking bench for acc_mem_arbiter with a behavioural
// synchronous-read memory attached to the memory port.
module tb_acc_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we, io_req, io_we;
    logic [15:0] cpu_addr, cpu_wdata, io_addr, io_wdata;
    logic        cpu_gnt, cpu_rvalid, io_gnt, io_rvalid;
    logic [15:0] cpu_rdata, io_rdata;
    logic [9:0]  mem_addr;
    logic [15:0] mem_data, mem_q;
    logic        mem_we, busy;

    logic [15:0] mem [1024];

    int n_checks = 0;
    int n_errors = 0;

    acc_mem_arbiter dut (
        .CLK        (clk),
        .Reset      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .io_req     (io_req),
        .io_we      (io_we),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_gnt     (io_gnt),
        .io_rvalid  (io_rvalid),
        .io_rdata   (io_rdata),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .mem_q      (mem_q),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_data;
        mem_q <= mem[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"},   32'(busy), 0);
        check_eq({tag, "_gnt"},    32'({cpu_gnt, io_gnt}), 0);
        check_eq({tag, "_rvalid"}, 32'({cpu_rvalid, io_rvalid}), 0);
        check_eq({tag, "_mem_we"}, 32'(mem_we), 0);
    endtask

    initial begin
        int          ng;
        logic        seq [10];
        logic [31:0] exp_io;

        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        io_req  = 0; io_we  = 0; io_addr  = 0; io_wdata  = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("rst");
        check_eq("rst_mem_addr", 32'(mem_addr), 0);
        check_eq("rst_mem_data", 32'(mem_data), 0);
        check_eq("rst_rdata", 32'({cpu_rdata, io_rdata}), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Request withdrawn before any edge samples it: no transaction.
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0012; cpu_wdata = 16'h1111;
        #3 cpu_req = 0;
        tick();
        check_idle_outputs("withdraw");

        // CPU write 0x0012 <= 0xBEEF.
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0012; cpu_wdata = 16'hBEEF;
        tick();
        check_eq("wr_gnt", 32'(cpu_gnt), 1);
        check_eq("wr_io_gnt", 32'(io_gnt), 0);
        check_eq("wr_mem_we", 32'(mem_we), 1);
        check_eq("wr_mem_addr", 32'(mem_addr), 32'h012);
        check_eq("wr_mem_data", 32'(mem_data), 32'hBEEF);
        cpu_req = 0;
        tick();
        check_idle_outputs("wr_end");

        // CPU read back 0x0012.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0012;
        tick();
        check_eq("rd_gnt", 32'(cpu_gnt), 1);
        check_eq("rd_mem_we", 32'(mem_we), 0);
        cpu_req = 0;
        tick();
        check_eq("rd_rvalid", 32'(cpu_rvalid), 1);
        check_eq("rd_rdata", 32'(cpu_rdata), 32'hBEEF);
        check_eq("rd_io_rvalid", 32'(io_rvalid), 0);
        tick();
        check_idle_outputs("rd_end");
        check_eq("rd_hold", 32'(cpu_rdata), 32'hBEEF);

        // IO write then read on its own.
        io_req = 1; io_we = 1; io_addr = 16'h0040; io_wdata = 16'hA5A5;
        tick();
        check_eq("io_wr_gnt", 32'({cpu_gnt, io_gnt}), 32'b01);
        io_req = 0;
        tick();
        io_req = 1; io_we = 0;
        tick();
        check_eq("io_rd_gnt", 32'({cpu_gnt, io_gnt}), 32'b01);
        io_req = 0;
        tick();
        check_eq("io_rd_rvalid", 32'({cpu_rvalid, io_rvalid}), 32'b01);
        check_eq("io_rd_rdata", 32'(io_rdata), 32'hA5A5);
        check_eq("io_rd_cpu_hold", 32'(cpu_rdata), 32'hBEEF);
        tick();

        // Address truncation.
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'hFC05; cpu_wdata = 16'h1234;
        tick();
        check_eq("trunc_addr", 32'(mem_addr), 32'h005);
        cpu_req = 0;
        tick();

        // Back-to-back reads with cpu_req held: ACCESS/RDWAIT alternate.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0012;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq($sformatf("b2b_gnt_%0d", i), 32'(cpu_gnt), 32'(i % 2 == 0));
            check_eq($sformatf("b2b_rvalid_%0d", i), 32'(cpu_rvalid), 32'(i % 2 == 1));
            check_eq($sformatf("b2b_busy_%0d", i), 32'(busy), 1);
            if (i % 2 == 1) check_eq($sformatf("b2b_rdata_%0d", i), 32'(cpu_rdata), 32'hBEEF);
            if (i == 4) cpu_req = 0;
        end
        tick();
        check_eq("b2b_end_busy", 32'(busy), 0);

        // Contention: both requesters hold write requests.
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 16'h1111;
        io_req  = 1; io_we  = 1; io_addr  = 16'h0030; io_wdata  = 16'h2222;
        ng = 0;
        for (int c = 0; c < 40 && ng < 10; c++) begin
            tick();
            if (cpu_gnt || io_gnt) begin
                check_eq("cont_excl", 32'(cpu_gnt & io_gnt), 0);
                seq[ng] = io_gnt;
                ng++;
            end
        end
        cpu_req = 0; io_req = 0;
        check_eq("cont_count", 32'(ng), 10);
        for (int i = 0; i < ng; i++) begin
`ifdef ACC_ARB_STARVE_GUARD_EN
            exp_io = 32'(i % 5 == 4);
`else
            exp_io = 0;
`endif
            check_eq($sformatf("cont_io_%0d", i), 32'(seq[i]), exp_io);
        end
        tick();

        // Reset while a read is in RDWAIT.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0012;
        tick();
        cpu_req = 0;
        tick();
        check_eq("rstrd_rvalid_pre", 32'(cpu_rvalid), 1);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("rstrd");
        check_eq("rstrd_rdata", 32'({cpu_rdata, io_rdata}), 0);
        check_eq("rstrd_mem_addr", 32'(mem_addr), 0);
        check_eq("rstrd_mem_data", 32'(mem_data), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("rstrd_post_rvalid_%0d", i), 32'({cpu_rvalid, io_rvalid}), 0);
            check_eq($sformatf("rstrd_post_busy_%0d", i), 32'(busy), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
